el2_pmp_check_pipe: RTL and testbench
=====================================

EL2_PMP_CHECK_PIPE -- requirements
Module: el2_pmp_check_pipe

Interface
REQ-001 SHALL have parameter PMP_CHANNELS, default 3, number of independent access-check channels (1..8).
REQ-002 SHALL have parameter PMP_ENTRIES, default 16, number of PMP regions checked (1..64).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port pmp_pmpcfg  input  el2_pmp_cfg_pkt_t[PMP_ENTRIES]  per-entry {lock, mode[1:0], execute, write, read}.
REQ-006 SHALL have port pmp_pmpaddr  input  32 x PMP_ENTRIES  per-entry physical address bits [33:2].
REQ-007 SHALL have port req_valid  input  PMP_CHANNELS  per-channel request strobe.
REQ-008 SHALL have port req_addr  input  32 x PMP_CHANNELS  byte address per channel.
REQ-009 SHALL have port req_type  input  el2_pmp_type_pkt_t[PMP_CHANNELS]  access kind {read, write, execute}, one-hot.
REQ-010 SHALL have port req_umode  input  PMP_CHANNELS  1 = user-mode access, 0 = machine-mode access.
REQ-011 SHALL have port rsp_valid  output  PMP_CHANNELS  result strobe, one cycle after req_valid.
REQ-012 SHALL have port rsp_err  output  PMP_CHANNELS  1 = access denied; meaningful only with rsp_valid.
REQ-013 SHALL have port fault_clr  input  1  clears fault log and violation counter.
REQ-014 SHALL have ports fault_valid (1), fault_chan ($clog2(PMP_CHANNELS), minimum 1), fault_addr (32), fault_type (el2_pmp_type_pkt_t), fault_cnt (16), all outputs forming the fault log.

Function
REQ-015 SHALL evaluate every channel in parallel with fixed latency of exactly 1 cycle: rsp_valid[c] = req_valid[c] registered; rsp_err[c] = registered decision using pmpcfg/pmpaddr values present in the request cycle.
REQ-016 SHALL accept a new request on every channel every cycle; no backpressure.
REQ-017 SHALL match per entry on mode: OFF never; TOR when pmpaddr[i-1] <= addr[33:2] < pmpaddr[i], with lower bound 0 for entry 0; NA4 when addr[33:2] == pmpaddr[i]; NAPOT by trailing-ones mask of pmpaddr[i].
REQ-018 SHALL treat TOR with pmpaddr[i-1] >= pmpaddr[i] as no match.
REQ-019 SHALL give priority to lowest-index matching entry; higher-index matches are ignored.
REQ-020 SHALL, on match, deny when the requested permission bit is 0 and (req_umode = 1 or lock = 1); machine-mode access to an unlocked entry is always allowed.
REQ-021 SHALL, on no match, allow machine-mode and deny user-mode accesses.
REQ-022 SHALL hold rsp_err = 0 whenever rsp_valid = 0.

Reset
REQ-023 SHALL, in any cycle with rst = 1, drive next-cycle rsp_valid = 0, rsp_err = 0, fault_valid = 0, fault_chan = 0, fault_addr = 0, fault_type = 0, fault_cnt = 0.
REQ-024 SHALL discard any request presented in a cycle with rst = 1; no response is produced for it.

Configuration
REQ-025 SHALL compile the fault log only when macro RV_PMP_FAULT_LOG_EN is defined.
REQ-026 SHALL, with RV_PMP_FAULT_LOG_EN: on the first denied response while fault_valid = 0, set fault_valid and capture the channel, address and type; with several denials in one cycle, capture the lowest channel; the log stays frozen until fault_clr.
REQ-027 SHALL, with RV_PMP_FAULT_LOG_EN: increment fault_cnt by the number of denied responses each cycle, saturating at 0xFFFF.
REQ-028 SHALL, with RV_PMP_FAULT_LOG_EN: on fault_clr with simultaneous denials, clear then capture, giving fault_valid = 1 with the new fault and fault_cnt = that cycle's denial count.
REQ-029 SHALL, without RV_PMP_FAULT_LOG_EN, tie all fault_* outputs to 0 and ignore fault_clr.

Structure
REQ-030 SHALL take el2_pmp_cfg_pkt_t, el2_pmp_type_pkt_t and the mode encodings (OFF=0, TOR=1, NA4=2, NAPOT=3) from el2_pkg.
REQ-031 SHALL instantiate sub-module el2_pmp_entry_match per entry per channel: combinational, outputs match and permit.

Verification
REQ-032 SHALL test: entry0 NAPOT pmpaddr=0x0000_01FF (base 0x0, 4 KiB), cfg R only; U-mode write to 0x100 -> rsp_err=1 next cycle; U-mode read -> rsp_err=0.
REQ-033 SHALL test: entry1 TOR pmpaddr0=0x400, pmpaddr1=0x800, cfg RWX unlocked; M-mode exec at 0x3000 with no match -> err=0; U-mode at 0x3000 -> err=1; U-mode at 0x1FFC -> err=0, at 0x2000 -> err=1.
REQ-034 SHALL test: overlapping entries, entry2 NA4 0x0000_0100 no-perm locked, entry3 NAPOT RWX covering it; M-mode read 0x400 -> err=1 (priority plus lock).
REQ-035 SHALL test: 3 channels all denied in one cycle -> fault_chan=0, fault_cnt=3; next cycle fault_clr plus channel 2 denied -> fault_chan=2, fault_cnt=1.
REQ-036 SHALL test: fault_cnt preloaded to 0xFFFE by 0xFFFE single denials, then 3 denials -> 0xFFFF; rst asserted with req_valid=1 -> rsp_valid=0 next cycle and all outputs 0.

Source files
------------

// File: rtl/el2_pkg.sv
// Shared PMP types: per-entry configuration, access kind and address-matching modes.
package el2_pkg;

  typedef enum logic [1:0] {
    PMP_OFF   = 2'd0,
    PMP_TOR   = 2'd1,
    PMP_NA4   = 2'd2,
    PMP_NAPOT = 2'd3
  } el2_pmp_mode_e;

  typedef struct packed {
    logic          lock;
    el2_pmp_mode_e mode;
    logic          execute;
    logic          write;
    logic          read;
  } el2_pmp_cfg_pkt_t;

  typedef struct packed {
    logic read;
    logic write;
    logic execute;
  } el2_pmp_type_pkt_t;

  // Bits that must equal pmpaddr: clears the trailing ones and the zero just above them.
  function automatic logic [31:0] napot_mask(input logic [31:0] pmpaddr);
    return ~(pmpaddr ^ (pmpaddr + 32'd1));
  endfunction

endpackage

// File: rtl/el2_pmp_entry_match.sv
// Combinational check of one access against one PMP entry: address match and permission.
module el2_pmp_entry_match
  import el2_pkg::*;
(
  input  el2_pmp_cfg_pkt_t  cfg,
  input  logic [31:0]       pmpaddr_prev,
  input  logic [31:0]       pmpaddr,
  input  logic [31:0]       word_addr,
  input  el2_pmp_type_pkt_t acc_type,
  input  logic              umode,
  output logic              match,
  output logic              permit
);

  always_comb begin
    // NOTE: every path assigns match, so no latch is inferred.
    match = 1'b0;
    case (cfg.mode)
      PMP_TOR:   match = (pmpaddr_prev < pmpaddr) && (word_addr >= pmpaddr_prev) &&
                         (word_addr < pmpaddr);
      PMP_NA4:   match = (word_addr == pmpaddr);
      PMP_NAPOT: match = ((word_addr ^ pmpaddr) & napot_mask(pmpaddr)) == 32'd0;
      default:   match = 1'b0;
    endcase
  end

  // Machine mode bypasses the permission bits of unlocked entries.
  assign permit = (|(acc_type & {cfg.read, cfg.write, cfg.execute})) || (!umode && !cfg.lock);

endmodule

// File: rtl/el2_pmp_check_pipe.sv
// Multi-channel PMP checker with one-cycle response latency.
// Optional fault log and violation counter are compiled in with RV_PMP_FAULT_LOG_EN.
module el2_pmp_check_pipe
  import el2_pkg::*;
#(
  parameter int PMP_CHANNELS = 3,
  parameter int PMP_ENTRIES  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  el2_pmp_cfg_pkt_t        pmp_pmpcfg  [PMP_ENTRIES],
  input  logic [31:0]             pmp_pmpaddr [PMP_ENTRIES],
  input  logic [PMP_CHANNELS-1:0] req_valid,
  input  logic [31:0]             req_addr    [PMP_CHANNELS],
  input  el2_pmp_type_pkt_t       req_type    [PMP_CHANNELS],
  input  logic [PMP_CHANNELS-1:0] req_umode,
  output logic [PMP_CHANNELS-1:0] rsp_valid,
  output logic [PMP_CHANNELS-1:0] rsp_err,
  input  logic                    fault_clr,
  output logic                    fault_valid,
  output logic [((PMP_CHANNELS > 1) ? $clog2(PMP_CHANNELS) : 1)-1:0] fault_chan,
  output logic [31:0]             fault_addr,
  output el2_pmp_type_pkt_t       fault_type,
  output logic [15:0]             fault_cnt
);

  localparam int CHAN_W = (PMP_CHANNELS > 1) ? $clog2(PMP_CHANNELS) : 1;

  logic [31:0] addr_prev [PMP_ENTRIES];
  logic [PMP_CHANNELS-1:0][PMP_ENTRIES-1:0] hit;
  logic [PMP_CHANNELS-1:0][PMP_ENTRIES-1:0] ok;
  logic [PMP_CHANNELS-1:0] deny;

  for (genvar e = 0; e < PMP_ENTRIES; e++) begin : g_prev
    if (e == 0) begin : g_first
      assign addr_prev[e] = 32'd0;
    end else begin : g_rest
      assign addr_prev[e] = pmp_pmpaddr[e-1];
    end
  end

  for (genvar c = 0; c < PMP_CHANNELS; c++) begin : g_chan
    for (genvar e = 0; e < PMP_ENTRIES; e++) begin : g_entry
      el2_pmp_entry_match u_match (
        .cfg          (pmp_pmpcfg[e]),
        .pmpaddr_prev (addr_prev[e]),
        .pmpaddr      (pmp_pmpaddr[e]),
        .word_addr    ({2'b00, req_addr[c][31:2]}),
        .acc_type     (req_type[c]),
        .umode        (req_umode[c]),
        .match        (hit[c][e]),
        .permit       (ok[c][e])
      );
    end
  end

  // Walking entries from high to low leaves the lowest-index match in control.
  always_comb begin
    for (int c = 0; c < PMP_CHANNELS; c++) begin
      deny[c] = req_valid[c] & req_umode[c];
      for (int e = PMP_ENTRIES - 1; e >= 0; e--) begin
        if (hit[c][e]) deny[c] = req_valid[c] & ~ok[c][e];
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      rsp_valid <= '0;
      rsp_err   <= '0;
    end else begin
      rsp_valid <= req_valid;
      rsp_err   <= deny;
    end
  end

`ifdef RV_PMP_FAULT_LOG_EN
  logic [CHAN_W-1:0]  first_chan;
  logic [31:0]        first_addr;
  el2_pmp_type_pkt_t  first_type;
  logic [16:0]        cnt_sum;

  always_comb begin
    first_chan = '0;
    first_addr = '0;
    first_type = '0;
    cnt_sum    = {1'b0, fault_clr ? 16'd0 : fault_cnt};
    for (int c = PMP_CHANNELS - 1; c >= 0; c--) begin
      if (deny[c]) begin
        first_chan = CHAN_W'(c);
        first_addr = req_addr[c];
        first_type = req_type[c];
      end
    end
    for (int c = 0; c < PMP_CHANNELS; c++) cnt_sum = cnt_sum + 17'(deny[c]);
  end

  // Clear and capture in the same cycle resolves to the fresh fault.
  always_ff @(posedge clk) begin
    if (rst) begin
      fault_valid <= 1'b0;
      fault_chan  <= '0;
      fault_addr  <= '0;
      fault_type  <= '0;
      fault_cnt   <= '0;
    end else begin
      fault_cnt <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
      if ((fault_clr || !fault_valid) && |deny) begin
        fault_valid <= 1'b1;
        fault_chan  <= first_chan;
        fault_addr  <= first_addr;
        fault_type  <= first_type;
      end else if (fault_clr) begin
        fault_valid <= 1'b0;
        fault_chan  <= '0;
        fault_addr  <= '0;
        fault_type  <= '0;
      end
    end
  end
`else
  logic unused_fault_clr;
  assign unused_fault_clr = fault_clr;
  assign fault_valid      = 1'b0;
  assign fault_chan       = '0;
  assign fault_addr       = '0;
  assign fault_type       = '0;
  assign fault_cnt        = '0;
`endif

endmodule

// File: tb/tb_el2_pmp_check_pipe.sv
// Directed bench for el2_pmp_check_pipe; fault-log expectations follow RV_PMP_FAULT_LOG_EN.
module tb_el2_pmp_check_pipe;
  import el2_pkg::*;

  localparam int CH = 3;
  localparam int EN = 16;
`ifdef RV_PMP_FAULT_LOG_EN
  localparam bit LOG = 1'b1;
`else
  localparam bit LOG = 1'b0;
`endif

  localparam logic [2:0] RD = 3'b100, WR = 3'b010, EX = 3'b001, RWX = 3'b111, NOP = 3'b000;

  logic              clk = 1'b0;
  logic              rst;
  el2_pmp_cfg_pkt_t  pmp_pmpcfg  [EN];
  logic [31:0]       pmp_pmpaddr [EN];
  logic [CH-1:0]     req_valid;
  logic [31:0]       req_addr    [CH];
  el2_pmp_type_pkt_t req_type    [CH];
  logic [CH-1:0]     req_umode;
  logic [CH-1:0]     rsp_valid;
  logic [CH-1:0]     rsp_err;
  logic              fault_clr;
  logic              fault_valid;
  logic [1:0]        fault_chan;
  logic [31:0]       fault_addr;
  el2_pmp_type_pkt_t fault_type;
  logic [15:0]       fault_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  el2_pmp_check_pipe #(.PMP_CHANNELS(CH), .PMP_ENTRIES(EN)) dut (
    .clk         (clk),
    .rst         (rst),
    .pmp_pmpcfg  (pmp_pmpcfg),
    .pmp_pmpaddr (pmp_pmpaddr),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_type    (req_type),
    .req_umode   (req_umode),
    .rsp_valid   (rsp_valid),
    .rsp_err     (rsp_err),
    .fault_clr   (fault_clr),
    .fault_valid (fault_valid),
    .fault_chan  (fault_chan),
    .fault_addr  (fault_addr),
    .fault_type  (fault_type),
    .fault_cnt   (fault_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lg(input logic [31:0] v);
    return LOG ? v : 32'd0;
  endfunction

  task automatic set_entry(input int i, input logic lock, input el2_pmp_mode_e mode,
                           input logic [2:0] rwx, input logic [31:0] addr);
    pmp_pmpcfg[i]  = '{lock: lock, mode: mode, execute: rwx[0], write: rwx[1], read: rwx[2]};
    pmp_pmpaddr[i] = addr;
  endtask

  task automatic drive(input int c, input logic v, input logic [31:0] a,
                       input logic [2:0] t, input logic u);
    req_valid[c] = v;
    req_addr[c]  = a;
    req_type[c]  = el2_pmp_type_pkt_t'(t);
    req_umode[c] = u;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_fault(input string tag, input logic v, input logic [1:0] ch,
                             input logic [31:0] a, input logic [2:0] t, input logic [15:0] n);
    check({tag, "_valid"}, 32'(fault_valid), lg(32'(v)));
    check({tag, "_chan"},  32'(fault_chan),  lg(32'(ch)));
    check({tag, "_addr"},  fault_addr,       lg(a));
    check({tag, "_type"},  32'(fault_type),  lg(32'(t)));
    check({tag, "_cnt"},   32'(fault_cnt),   lg(32'(n)));
  endtask

  initial begin
    rst       = 1'b1;
    fault_clr = 1'b0;
    for (int i = 0; i < EN; i++) set_entry(i, 1'b0, PMP_OFF, NOP, 32'd0);
    for (int c = 0; c < CH; c++) drive(c, 1'b0, 32'd0, RD, 1'b0);
    cycle();
    cycle();
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_err",   32'(rsp_err),   32'd0);
    check_fault("reset_fault", 1'b0, 2'd0, 32'd0, NOP, 16'd0);
    rst = 1'b0;

    // Entry 0 NAPOT 4 KiB at 0, read-only
    set_entry(0, 1'b0, PMP_NAPOT, RD, 32'h0000_01FF);
    drive(0, 1'b1, 32'h100, WR, 1'b1);
    drive(1, 1'b1, 32'h100, RD, 1'b1);
    drive(2, 1'b1, 32'h100, WR, 1'b0);
    cycle();
    check("napot_rsp_valid", 32'(rsp_valid), 32'h7);
    check("napot_rsp_err",   32'(rsp_err),   32'h1);
    check_fault("napot_fault", 1'b1, 2'd0, 32'h100, WR, 16'd1);

    for (int c = 0; c < CH; c++) drive(c, 1'b0, 32'h100, WR, 1'b1);
    cycle();
    check("idle_rsp_valid", 32'(rsp_valid), 32'd0);
    check("idle_rsp_err",   32'(rsp_err),   32'd0);

    // Entry 1 TOR words [0x400,0x800) = bytes 0x1000..0x1FFF
    set_entry(0, 1'b0, PMP_OFF, NOP, 32'h400);
    set_entry(1, 1'b0, PMP_TOR, RWX, 32'h800);
    drive(0, 1'b1, 32'h3000, EX, 1'b0);
    drive(1, 1'b1, 32'h3000, EX, 1'b1);
    drive(2, 1'b1, 32'h1FFC, RD, 1'b1);
    cycle();
    check("tor_a_rsp_err", 32'(rsp_err), 32'h2);

    drive(0, 1'b1, 32'h2000, RD, 1'b1);
    drive(1, 1'b1, 32'h1000, RD, 1'b1);
    drive(2, 1'b1, 32'h0FFC, WR, 1'b1);
    cycle();
    check("tor_b_rsp_err", 32'(rsp_err), 32'h5);

    // Inverted TOR bounds never match
    set_entry(0, 1'b0, PMP_OFF, NOP, 32'h800);
    set_entry(1, 1'b0, PMP_TOR, RWX, 32'h400);
    drive(0, 1'b1, 32'h1000, RD, 1'b1);
    drive(1, 1'b0, 32'h1000, RD, 1'b1);
    drive(2, 1'b1, 32'h1000, RD, 1'b0);
    cycle();
    check("tor_inv_rsp_valid", 32'(rsp_valid), 32'h5);
    check("tor_inv_rsp_err",   32'(rsp_err),   32'h1);

    // Locked no-perm NA4 at byte 0x400 beats a later RWX NAPOT
    set_entry(0, 1'b0, PMP_OFF,   NOP, 32'h400);
    set_entry(1, 1'b0, PMP_TOR,   RWX, 32'h800);
    set_entry(2, 1'b1, PMP_NA4,   NOP, 32'h100);
    set_entry(3, 1'b0, PMP_NAPOT, RWX, 32'h1FF);
    drive(0, 1'b1, 32'h400, RD, 1'b0);
    drive(1, 1'b1, 32'h404, RD, 1'b0);
    drive(2, 1'b1, 32'h404, WR, 1'b1);
    cycle();
    check("prio_rsp_valid", 32'(rsp_valid), 32'h7);
    check("prio_rsp_err",   32'(rsp_err),   32'h1);

    // Fault log: clear, then three simultaneous denials
    for (int c = 0; c < CH; c++) drive(c, 1'b0, 32'h0, RD, 1'b0);
    fault_clr = 1'b1;
    cycle();
    fault_clr = 1'b0;
    check_fault("clr_fault", 1'b0, 2'd0, 32'd0, NOP, 16'd0);

    drive(0, 1'b1, 32'h3000, RD, 1'b1);
    drive(1, 1'b1, 32'h3004, WR, 1'b1);
    drive(2, 1'b1, 32'h3008, EX, 1'b1);
    cycle();
    check("three_rsp_err", 32'(rsp_err), 32'h7);
    check_fault("three_fault", 1'b1, 2'd0, 32'h3000, RD, 16'd3);

    fault_clr = 1'b1;
    drive(0, 1'b1, 32'h3000, RD, 1'b0);
    drive(1, 1'b0, 32'h3004, WR, 1'b1);
    drive(2, 1'b1, 32'h300C, WR, 1'b1);
    cycle();
    fault_clr = 1'b0;
    check("clrcap_rsp_err", 32'(rsp_err), 32'h4);
    check_fault("clrcap_fault", 1'b1, 2'd2, 32'h300C, WR, 16'd1);

    drive(0, 1'b0, 32'h3000, RD, 1'b0);
    drive(1, 1'b1, 32'h3010, RD, 1'b1);
    drive(2, 1'b0, 32'h300C, WR, 1'b1);
    cycle();
    check_fault("frozen_fault", 1'b1, 2'd2, 32'h300C, WR, 16'd2);

    // Counter preload to 0xFFFE, then saturation
    for (int c = 0; c < CH; c++) drive(c, 1'b0, 32'h0, RD, 1'b0);
    fault_clr = 1'b1;
    cycle();
    fault_clr = 1'b0;
    drive(0, 1'b1, 32'h3000, RD, 1'b1);
    repeat (16'hFFFE) cycle();
    check("preload_cnt", 32'(fault_cnt), lg(32'hFFFE));

    drive(1, 1'b1, 32'h3004, RD, 1'b1);
    drive(2, 1'b1, 32'h3008, RD, 1'b1);
    cycle();
    check("sat_cnt", 32'(fault_cnt), lg(32'hFFFF));
    cycle();
    check("sat_hold_cnt", 32'(fault_cnt), lg(32'hFFFF));

    // Reset with live requests
    rst = 1'b1;
    cycle();
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_err",   32'(rsp_err),   32'd0);
    check_fault("rst_fault", 1'b0, 2'd0, 32'd0, NOP, 16'd0);
    rst = 1'b0;
    for (int c = 0; c < CH; c++) drive(c, 1'b0, 32'h0, RD, 1'b0);
    cycle();
    check("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
